uart_tx_fifo: RTL and testbench

//  Parametrised successor UART transmitter with a write-side FIFO, runtime frame format and break generation.
//  5-8 data bits (LSB first), none/space/even/odd parity, 1 or 2 stop bits.

---
 rtl/uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write-side FIFO: runtime 5-8 data bits, parity mode,
// 1/2 stop bits and break generation. The tx pad is driven from a register.
module uart_tx_fifo #(
    parameter int   CLK_DIV_WIDTH = 8,
    parameter int   FIFO_AW       = 4,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic [1:0]               data_bits,
    input  logic [1:0]               parity_mode,
    input  logic                     stop2,
    input  logic                     brk,
    input  logic [7:0]               datai,
    input  logic                     we,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     full,
    output logic [FIFO_AW:0]         level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [7:0]               mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]       wr_ptr_reg;
    logic [FIFO_AW-1:0]       rd_ptr_reg;
    logic [FIFO_AW:0]         count_reg;
    logic                     overflow_reg;
    logic                     push;
    logic                     pop;
    logic                     empty;
    logic [7:0]               rd_data;

    state_t                   state_reg, state_next;
    logic [CLK_DIV_WIDTH-1:0] baud_cnt_reg, baud_cnt_next;
    logic [CLK_DIV_WIDTH-1:0] reload;
    logic                     bit_end;
    logic [7:0]               shift_reg, shift_next;
    logic [2:0]               bit_idx_reg, bit_idx_next;
    logic [2:0]               last_idx_reg, last_idx_next;
    logic [1:0]               pmode_reg, pmode_next;
    logic                     stop2_reg, stop2_next;
    logic                     par_reg, par_next;
    logic                     phase_reg, phase_next;
    logic                     brk_rel_reg, brk_rel_next;
    logic                     done_reg, done_next;
    logic                     tx_reg, line;
    logic [7:0]               masked;
    logic                     par_calc;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH);
    assign push    = we && !full;
    assign rd_data = mem[rd_ptr_reg];
    assign reload  = (clk_div == '0) ? '0 : clk_div - 1'b1;
    assign bit_end = (baud_cnt_reg == '0);

    assign tx       = tx_reg;
    assign level    = count_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != S_IDLE) || !empty;
    assign done     = done_reg;

    // Parity over only the bits that will actually be sent.
    assign masked = rd_data & (8'hFF >> (2'd3 - data_bits));
    always_comb begin
        par_calc = 1'b0;
        case (parity_mode)
            2'd2:    par_calc = ^masked;
            2'd3:    par_calc = ~(^masked);
            default: par_calc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= datai;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (we && full) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        last_idx_next = last_idx_reg;
        pmode_next    = pmode_reg;
        stop2_next    = stop2_reg;
        par_next      = par_reg;
        phase_next    = phase_reg;
        brk_rel_next  = brk_rel_reg;
        done_next     = 1'b0;
        pop           = 1'b0;
        baud_cnt_next = bit_end ? reload : baud_cnt_reg - 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (brk) begin
                    state_next   = S_BREAK;
                    brk_rel_next = 1'b0;
                end else if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx_reg + 1'b1;
                    phase_next   = 1'b0;
                    if (bit_idx_reg == last_idx_reg) begin
                        state_next = (pmode_reg != 2'd0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    phase_next = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_reg && !phase_reg) begin
                        phase_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        if (brk) begin
                            state_next   = S_BREAK;
                            brk_rel_next = 1'b0;
                        end else if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            S_BREAK: begin
                // Hold phase ignores the baud counter; release phase is two bit periods.
                if (!brk_rel_reg) begin
                    if (!brk) begin
                        brk_rel_next  = 1'b1;
                        phase_next    = 1'b0;
                        baud_cnt_next = reload;
                    end
                end else if (bit_end) begin
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                    end else if (brk) begin
                        brk_rel_next = 1'b0;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (pop) begin
            state_next    = S_START;
            baud_cnt_next = reload;
            shift_next    = rd_data;
            bit_idx_next  = 3'd0;
            last_idx_next = {1'b0, data_bits} + 3'd4;
            pmode_next    = parity_mode;
            stop2_next    = stop2;
            par_next      = par_calc;
        end
    end

    always_comb begin
        line = IDLE_LEVEL;
        case (state_reg)
            S_START:  line = ~IDLE_LEVEL;
            S_DATA:   line = shift_reg[0];
            S_PARITY: line = par_reg;
            S_BREAK:  line = brk_rel_reg ? IDLE_LEVEL : ~IDLE_LEVEL;
            default:  line = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            last_idx_reg <= 3'd7;
            pmode_reg    <= '0;
            stop2_reg    <= 1'b0;
            par_reg      <= 1'b0;
            phase_reg    <= 1'b0;
            brk_rel_reg  <= 1'b0;
            done_reg     <= 1'b0;
            tx_reg       <= IDLE_LEVEL;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            last_idx_reg <= last_idx_next;
            pmode_reg    <= pmode_next;
            stop2_reg    <= stop2_next;
            par_reg      <= par_next;
            phase_reg    <= phase_next;
            brk_rel_reg  <= brk_rel_next;
            done_reg     <= done_next;
            tx_reg       <= line;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line waveforms are compared sample by
// sample against waveforms built from the frame format rules.
module tb_uart_tx_fifo;

    logic       clk;
    logic       resetb;
    logic [7:0] clk_div;
    logic [1:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       brk;
    logic [7:0] datai;
    logic       we;
    logic       ovf_clr;
    logic       tx;
    logic       full;
    logic [2:0] level;
    logic       overflow;
    logic       busy;
    logic       done;

    uart_tx_fifo #(
        .CLK_DIV_WIDTH (8),
        .FIFO_AW       (2),
        .IDLE_LEVEL    (1'b1)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .clk_div     (clk_div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .brk         (brk),
        .datai       (datai),
        .we          (we),
        .ovf_clr     (ovf_clr),
        .tx          (tx),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] db;
        logic [1:0] pm;
        logic       s2;
        int         div;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;
    logic rec      = 1'b0;
    logic cap_tx[$];
    logic cap_done[$];
    logic exp_tx[$];
    logic exp_done[$];
    vec_t vecs[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Sample index j holds the line state after the j-th edge following begin_cap.
    always @(negedge clk) begin
        if (rec) begin
            cap_tx.push_back(tx);
            cap_done.push_back(done);
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endfunction

    function automatic logic ref_parity(logic [7:0] b, int n, logic [1:0] pm);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(b[i]);
        if (pm == 2'd2) return (ones % 2) == 1;
        if (pm == 2'd3) return (ones % 2) == 0;
        return 1'b0;
    endfunction

    function automatic void exp_run(logic v, int k);
        for (int i = 0; i < k; i++) begin
            exp_tx.push_back(v);
            exp_done.push_back(1'b0);
        end
    endfunction

    function automatic void exp_frame(logic [7:0] b, int n, logic [1:0] pm, logic s2, int d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(b[i]);
        if (pm != 2'd0) bits.push_back(ref_parity(b, n, pm));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) exp_run(bits[i], d);
        exp_done[exp_done.size() - 1] = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic begin_cap();
        @(posedge clk);
        #1;
        cap_tx.delete();
        cap_done.delete();
        exp_tx.delete();
        exp_done.delete();
        t   = 0;
        rec = 1'b1;
    endtask

    task automatic push_byte(logic [7:0] b);
        datai = b;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic finish_wave(string name);
        int   bad_tx;
        int   bad_dn;
        logic et;
        logic ed;
        bad_tx = -1;
        bad_dn = -1;
        while (cap_tx.size() < exp_tx.size() + 8) step();
        rec = 1'b0;
        for (int i = 0; i < cap_tx.size(); i++) begin
            et = (i < exp_tx.size()) ? exp_tx[i] : 1'b1;
            ed = (i < exp_done.size()) ? exp_done[i] : 1'b0;
            if (bad_tx < 0 && cap_tx[i] !== et) bad_tx = i;
            if (bad_dn < 0 && cap_done[i] !== ed) bad_dn = i;
        end
        checks += 2;
        if (bad_tx >= 0) begin
            failures++;
            $display("FAIL %s_tx: sample %0d got %b required %b", name, bad_tx,
                     cap_tx[bad_tx], (bad_tx < exp_tx.size()) ? exp_tx[bad_tx] : 1'b1);
        end
        if (bad_dn >= 0) begin
            failures++;
            $display("FAIL %s_done: sample %0d got %b required %b", name, bad_dn,
                     cap_done[bad_dn], (bad_dn < exp_done.size()) ? exp_done[bad_dn] : 1'b0);
        end
        $display("%s: %0d samples compared", name, cap_tx.size());
    endtask

    task automatic run_frame(vec_t v, string name);
        int d;
        int n;
        int di;
        d           = (v.div < 1) ? 1 : v.div;
        n           = int'(v.db) + 5;
        data_bits   = v.db;
        parity_mode = v.pm;
        stop2       = v.s2;
        clk_div     = 8'(v.div);
        begin_cap();
        exp_run(1'b1, 3);
        exp_frame(v.data, n, v.pm, v.s2, d);
        push_byte(v.data);
        repeat (3) step();
        // Format inputs move mid-frame; the frame in flight must not notice.
        data_bits   = 2'($urandom);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
        finish_wave(name);
        di = -1;
        for (int i = 0; i < cap_done.size(); i++) begin
            if (di < 0 && cap_done[i] === 1'b1) di = i;
        end
        chk({name, "_len"}, di - 2, v.exp_len);
        if (v.pm != 2'd0) chk({name, "_parity"}, int'(cap_tx[3 + (1 + n) * d]), int'(v.exp_par));
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_level"}, int'(level), 0);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   d;

        vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 4, 40, 1'b0};
        vecs[1] = '{8'h83, 2'd2, 2'd2, 1'b1, 3, 33, 1'b0};
        vecs[2] = '{8'h83, 2'd2, 2'd3, 1'b1, 3, 33, 1'b1};
        vecs[3] = '{8'h5A, 2'd0, 2'd1, 1'b0, 1,  8, 1'b0};
        vecs[4] = '{8'hFF, 2'd1, 2'd2, 1'b1, 2, 20, 1'b0};
        vecs[5] = '{8'h3C, 2'd3, 2'd3, 1'b0, 0, 11, 1'b1};
        vecs[6] = '{8'h01, 2'd1, 2'd2, 1'b0, 5, 45, 1'b1};
        vecs[7] = '{8'h96, 2'd3, 2'd2, 1'b0, 3, 33, 1'b0};

        resetb      = 1'b0;
        clk_div     = 8'd4;
        data_bits   = 2'd3;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        brk         = 1'b0;
        datai       = 8'h00;
        we          = 1'b0;
        ovf_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_level", int'(level), 0);
        chk("reset_full", int'(full), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        resetb = 1'b1;
        step();

        for (int k = 0; k < 7; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 10; k++) begin
            v.data  = 8'($urandom);
            v.db    = 2'($urandom);
            v.pm    = 2'($urandom);
            v.s2    = 1'($urandom);
            v.div   = $urandom_range(0, 6);
            n       = int'(v.db) + 5;
            d       = (v.div < 1) ? 1 : v.div;
            v.exp_len = (1 + n + ((v.pm != 2'd0) ? 1 : 0) + (v.s2 ? 2 : 1)) * d;
            v.exp_par = ref_parity(v.data, n, v.pm);
            run_frame(v, $sformatf("rnd%0d", k));
        end

        // Three back-to-back bytes, 8N1, two clocks per bit: contiguous frames.
        clk_div = 8'd2; data_bits = 2'd3; parity_mode = 2'd0; stop2 = 1'b0;
        begin_cap();
        exp_run(1'b1, 3);
        exp_frame(8'h12, 8, 2'd0, 1'b0, 2);
        exp_frame(8'hE7, 8, 2'd0, 1'b0, 2);
        exp_frame(8'h4D, 8, 2'd0, 1'b0, 2);
        push_byte(8'h12);
        push_byte(8'hE7);
        push_byte(8'h4D);
        // The first byte left the FIFO on the edge after it was written.
        chk("b2b_level_peak", int'(level), 2);
        finish_wave("b2b");
        chk("b2b_level_end", int'(level), 0);

        // Overflow with a depth-4 FIFO and a slow line.
        clk_div = 8'd255;
        begin_cap();
        exp_run(1'b1, 3);
        for (int k = 1; k <= 5; k++) exp_frame(8'(k * 17), 8, 2'd0, 1'b0, 255);
        for (int k = 1; k <= 6; k++) push_byte(8'(k * 17));
        chk("ovf_full", int'(full), 1);
        chk("ovf_level", int'(level), 4);
        chk("ovf_set", int'(overflow), 1);
        repeat (3) step();
        chk("ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(overflow), 0);
        finish_wave("ovf");

        // Break requested mid-frame; a second byte waits behind it.
        clk_div = 8'd4;
        begin_cap();
        exp_run(1'b1, 3);
        exp_frame(8'h3C, 8, 2'd0, 1'b0, 4);
        exp_run(1'b0, 29);
        exp_run(1'b1, 8);
        exp_frame(8'hC3, 8, 2'd0, 1'b0, 4);
        push_byte(8'h3C);
        while (t < 5) step();
        push_byte(8'hC3);
        while (t < 15) step();
        brk = 1'b1;
        while (t < 50) step();
        chk("brk_busy", int'(busy), 1);
        chk("brk_line", int'(tx), 0);
        chk("brk_level", int'(level), 1);
        while (t < 70) step();
        brk = 1'b0;
        finish_wave("brk");

        // Reset while data bits (all zero) are on the line.
        begin_cap();
        push_byte(8'h00);
        push_byte(8'h00);
        while (t < 15) step();
        rec = 1'b0;
        chk("pre_rst_tx", int'(tx), 0);
        chk("pre_rst_level", int'(level), 1);
        #3;
        resetb = 1'b0;
        #1;
        chk("rst_tx", int'(tx), 1);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_tx", int'(tx), 1);
        resetb = 1'b1;
        step();
        run_frame(vecs[7], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
